// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32IM MEM stage: data-memory req/ready port, store lane alignment, load extension, WB register; optional MEM_MISALIGN_TRAP_EN
module mem_access_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           EX_ALU_RESULT,
    input  logic [31:0]           EX_READ_DATA2,
    input  logic [2:0]            EX_FUNC3,
    input  logic [4:0]            EX_RD,
    input  logic                  EX_WRITE_ENABLE,
    input  logic                  EX_DATA_MEM_SELECT,
    input  logic                  EX_MEM_READ,
    input  logic                  EX_MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] DMEM_ADDR,
    output logic [31:0]           DMEM_WDATA,
    output logic [3:0]            DMEM_BYTE_EN,
    output logic                  DMEM_READ,
    output logic                  DMEM_WRITE,
    input  logic [31:0]           DMEM_RDATA,
    input  logic                  DMEM_READY,
    output logic [31:0]           MEM_RESULT,
    output logic [4:0]            MEM_RD,
    output logic                  MEM_WRITE_ENABLE,
    output logic                  MEM_STALL,
    output logic                  MEM_MISALIGN
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_next;
    logic [31:0] lat_addr, lat_data;
    logic [2:0]  lat_func3;
    logic [4:0]  lat_rd;
    logic        lat_we, lat_sel, lat_store;
    logic        mem_op, misalign, accept, misalign_q;
    logic [31:0] byte_shift, half_shift, load_ext;

    assign mem_op = EX_MEM_READ | EX_MEM_WRITE;

`ifdef MEM_MISALIGN_TRAP_EN
    // func3[1:0]: 00 byte, 01 half, anything else is a word access
    assign misalign = ((EX_FUNC3[1:0] == 2'b01) && EX_ALU_RESULT[0]) ||
                      (EX_FUNC3[1] && (EX_ALU_RESULT[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign accept       = (state == IDLE) && mem_op && !misalign;
    assign MEM_MISALIGN = misalign_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Memory port is driven only from the latched request, never from EX
    always_comb begin
        state_next   = state;
        MEM_STALL    = 1'b0;
        DMEM_ADDR    = '0;
        DMEM_WDATA   = '0;
        DMEM_BYTE_EN = 4'b0000;
        DMEM_READ    = 1'b0;
        DMEM_WRITE   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = ACCESS;
            end
            ACCESS: begin
                if (DMEM_READY) state_next = IDLE;
                MEM_STALL  = 1'b1;
                DMEM_ADDR  = {lat_addr[ADDR_WIDTH-1:2], 2'b00};
                DMEM_READ  = !lat_store;
                DMEM_WRITE = lat_store;
                case (lat_func3[1:0])
                    2'b00: begin
                        DMEM_BYTE_EN = 4'b0001 << lat_addr[1:0];
                        DMEM_WDATA   = {4{lat_data[7:0]}};
                    end
                    2'b01: begin
                        DMEM_BYTE_EN = lat_addr[1] ? 4'b1100 : 4'b0011;
                        DMEM_WDATA   = {2{lat_data[15:0]}};
                    end
                    default: begin
                        DMEM_BYTE_EN = 4'b1111;
                        DMEM_WDATA   = lat_data;
                    end
                endcase
            end
            default: state_next = IDLE;
        endcase
    end

    assign byte_shift = DMEM_RDATA >> {lat_addr[1:0], 3'b000};
    assign half_shift = DMEM_RDATA >> {lat_addr[1], 4'b0000};

    always_comb begin
        case (lat_func3[1:0])
            2'b00:   load_ext = {{24{byte_shift[7] & ~lat_func3[2]}}, byte_shift[7:0]};
            2'b01:   load_ext = {{16{half_shift[15] & ~lat_func3[2]}}, half_shift[15:0]};
            default: load_ext = DMEM_RDATA;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lat_addr         <= '0;
            lat_data         <= '0;
            lat_func3        <= '0;
            lat_rd           <= '0;
            lat_we           <= 1'b0;
            lat_sel          <= 1'b0;
            lat_store        <= 1'b0;
            misalign_q       <= 1'b0;
            MEM_RESULT       <= '0;
            MEM_RD           <= '0;
            MEM_WRITE_ENABLE <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mem_op) begin
                        MEM_RESULT       <= EX_ALU_RESULT;
                        MEM_RD           <= EX_RD;
                        MEM_WRITE_ENABLE <= EX_WRITE_ENABLE;
                    end else if (misalign) begin
                        misalign_q       <= 1'b1;
                        MEM_RESULT       <= EX_ALU_RESULT;
                        MEM_RD           <= EX_RD;
                        MEM_WRITE_ENABLE <= 1'b0;
                    end else begin
                        lat_addr         <= EX_ALU_RESULT;
                        lat_data         <= EX_READ_DATA2;
                        lat_func3        <= EX_FUNC3;
                        lat_rd           <= EX_RD;
                        lat_we           <= EX_WRITE_ENABLE;
                        lat_sel          <= EX_DATA_MEM_SELECT;
                        lat_store        <= EX_MEM_WRITE;
                        MEM_WRITE_ENABLE <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (DMEM_READY) begin
                        if (!lat_store) begin
                            MEM_RESULT       <= lat_sel ? load_ext : lat_addr;
                            MEM_RD           <= lat_rd;
                            MEM_WRITE_ENABLE <= lat_we;
                        end else begin
                            MEM_WRITE_ENABLE <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] EX_ALU_RESULT, EX_READ_DATA2;
    logic [2:0]  EX_FUNC3;
    logic [4:0]  EX_RD;
    logic        EX_WRITE_ENABLE, EX_DATA_MEM_SELECT, EX_MEM_READ, EX_MEM_WRITE;
    logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [3:0]  DMEM_BYTE_EN;
    logic        DMEM_READ, DMEM_WRITE, DMEM_READY;
    logic [31:0] MEM_RESULT;
    logic [4:0]  MEM_RD;
    logic        MEM_WRITE_ENABLE, MEM_STALL, MEM_MISALIGN;

    int checks = 0;
    int failures = 0;

    int          stalls;
    logic [31:0] a0, w0;
    logic [3:0]  be0;
    logic        rd0, wr0;

    mem_access_stage #(.ADDR_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .EX_ALU_RESULT(EX_ALU_RESULT), .EX_READ_DATA2(EX_READ_DATA2),
        .EX_FUNC3(EX_FUNC3), .EX_RD(EX_RD), .EX_WRITE_ENABLE(EX_WRITE_ENABLE),
        .EX_DATA_MEM_SELECT(EX_DATA_MEM_SELECT), .EX_MEM_READ(EX_MEM_READ),
        .EX_MEM_WRITE(EX_MEM_WRITE),
        .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_BYTE_EN(DMEM_BYTE_EN),
        .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE), .DMEM_RDATA(DMEM_RDATA),
        .DMEM_READY(DMEM_READY),
        .MEM_RESULT(MEM_RESULT), .MEM_RD(MEM_RD), .MEM_WRITE_ENABLE(MEM_WRITE_ENABLE),
        .MEM_STALL(MEM_STALL), .MEM_MISALIGN(MEM_MISALIGN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rd_req, input logic wr_req, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic we, input logic sel);
        EX_MEM_READ        = rd_req;
        EX_MEM_WRITE       = wr_req;
        EX_FUNC3           = f3;
        EX_ALU_RESULT      = addr;
        EX_READ_DATA2      = data;
        EX_RD              = rd;
        EX_WRITE_ENABLE    = we;
        EX_DATA_MEM_SELECT = sel;
    endtask

    task automatic nop_ex;
        EX_MEM_READ     = 1'b0;
        EX_MEM_WRITE    = 1'b0;
        EX_WRITE_ENABLE = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the first IDLE cycle after the access
    task automatic run_mem(input logic rq, input logic wq, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd, input logic we, input logic sel,
                           input logic [31:0] rdata, input int lat,
                           output int st, output logic [31:0] a, output logic [31:0] w,
                           output logic [3:0] be, output logic dr, output logic dw);
        logic done;
        done = 1'b0;
        st = 0; a = '0; w = '0; be = '0; dr = 1'b0; dw = 1'b0;
        step;
        drive(rq, wq, f3, addr, data, rd, we, sel);
        step;
        nop_ex;
        DMEM_RDATA = rdata;
        for (int c = 0; c < 20; c++) begin
            DMEM_READY = (c == lat);
            @(negedge CLK);
            if (!MEM_STALL) begin
                done = 1'b1;
                break;
            end
            if (c == 0) begin
                a = DMEM_ADDR; w = DMEM_WDATA; be = DMEM_BYTE_EN;
                dr = DMEM_READ; dw = DMEM_WRITE;
            end
            st++;
            step;
        end
        DMEM_READY = 1'b0;
        check("access_completes", 32'(done), 32'd1);
    endtask

    initial begin
        RST = 1'b1;
        DMEM_READY = 1'b0;
        DMEM_RDATA = '0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        #12;
        check("rst_result", MEM_RESULT, 32'h0);
        check("rst_stall", 32'(MEM_STALL), 32'd0);
        check("rst_dmem_read", 32'(DMEM_READ), 32'd0);
        step;
        RST = 1'b0;

        // ALU pass-through
        drive(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0);
        DMEM_READY = 1'b1;
        @(negedge CLK);
        check("alu_stall", 32'(MEM_STALL), 32'd0);
        check("ready_idle_no_read", 32'(DMEM_READ), 32'd0);
        step;
        DMEM_READY = 1'b0;
        nop_ex;
        @(negedge CLK);
        check("alu_result", MEM_RESULT, 32'h1234);
        check("alu_rd", 32'(MEM_RD), 32'd5);
        check("alu_we", 32'(MEM_WRITE_ENABLE), 32'd1);
        check("alu_stall2", 32'(MEM_STALL), 32'd0);

        // Reset in the middle of an access
        step;
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd9, 1'b1, 1'b1);
        step;
        nop_ex;
        @(negedge CLK);
        check("rstmid_read_before", 32'(DMEM_READ), 32'd1);
        step;
        RST = 1'b1;
        #1;
        check("rstmid_read", 32'(DMEM_READ), 32'd0);
        check("rstmid_stall", 32'(MEM_STALL), 32'd0);
        check("rstmid_result", MEM_RESULT, 32'h0);
        check("rstmid_rd", 32'(MEM_RD), 32'd0);
        step;
        RST = 1'b0;
        step;
        @(negedge CLK);
        check("rstmid_idle_stall", 32'(MEM_STALL), 32'd0);
        check("rstmid_idle_read", 32'(DMEM_READ), 32'd0);

        // SB 0x103, ready on third access cycle
        run_mem(1'b0, 1'b1, 3'b000, 32'h103, 32'hAB, 5'd0, 1'b0, 1'b0, 32'h0, 2,
                stalls, a0, w0, be0, rd0, wr0);
        check("sb_stalls", 32'(stalls), 32'd3);
        check("sb_addr", a0, 32'h100);
        check("sb_be", 32'(be0), 32'h8);
        check("sb_wdata", w0, 32'hABABABAB);
        check("sb_write", 32'(wr0), 32'd1);
        check("sb_we", 32'(MEM_WRITE_ENABLE), 32'd0);

        // LB 0x102 sign extension
        run_mem(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 32'h00800000, 0,
                stalls, a0, w0, be0, rd0, wr0);
        check("lb_stalls", 32'(stalls), 32'd1);
        check("lb_be", 32'(be0), 32'h4);
        check("lb_read", 32'(rd0), 32'd1);
        check("lb_result", MEM_RESULT, 32'hFFFFFF80);
        check("lb_rd", 32'(MEM_RD), 32'd4);
        check("lb_we", 32'(MEM_WRITE_ENABLE), 32'd1);

        run_mem(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 32'h00800000, 0,
                stalls, a0, w0, be0, rd0, wr0);
        check("lbu_result", MEM_RESULT, 32'h00000080);

        run_mem(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 32'hBEEF0000, 1,
                stalls, a0, w0, be0, rd0, wr0);
        check("lhu_be", 32'(be0), 32'hC);
        check("lhu_stalls", 32'(stalls), 32'd2);
        check("lhu_result", MEM_RESULT, 32'h0000BEEF);

        run_mem(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 5'd6, 1'b1, 1'b1, 32'h00008001, 0,
                stalls, a0, w0, be0, rd0, wr0);
        check("lh_be", 32'(be0), 32'h3);
        check("lh_result", MEM_RESULT, 32'hFFFF8001);

        // Both read and write: treated as store
        run_mem(1'b1, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd8, 1'b1, 1'b1, 32'h0, 0,
                stalls, a0, w0, be0, rd0, wr0);
        check("sh_wdata", w0, 32'hABCDABCD);
        check("sh_be", 32'(be0), 32'hC);
        check("rw_is_write", 32'(wr0), 32'd1);
        check("rw_no_read", 32'(rd0), 32'd0);
        check("rw_we", 32'(MEM_WRITE_ENABLE), 32'd0);

        run_mem(1'b0, 1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 32'h0, 0,
                stalls, a0, w0, be0, rd0, wr0);
        check("sw_be", 32'(be0), 32'hF);
        check("sw_wdata", w0, 32'hDEADBEEF);

        // Undefined func3 behaves as word; select=0 returns the address
        run_mem(1'b1, 1'b0, 3'b111, 32'h304, 32'h0, 5'd11, 1'b1, 1'b1, 32'h87654321, 0,
                stalls, a0, w0, be0, rd0, wr0);
        check("f3_111_be", 32'(be0), 32'hF);
        check("f3_111_result", MEM_RESULT, 32'h87654321);

        run_mem(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd12, 1'b1, 1'b0, 32'h55555555, 0,
                stalls, a0, w0, be0, rd0, wr0);
        check("sel0_result", MEM_RESULT, 32'h300);
        check("sel0_rd", 32'(MEM_RD), 32'd12);

        // Back-to-back LW then ADD
        step;
        drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd10, 1'b1, 1'b1);
        DMEM_RDATA = 32'hCAFEF00D;
        step;
        drive(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd7, 1'b1, 1'b0);
        DMEM_READY = 1'b1;
        @(negedge CLK);
        check("b2b_stall", 32'(MEM_STALL), 32'd1);
        step;
        DMEM_READY = 1'b0;
        @(negedge CLK);
        check("b2b_bubble_stall", 32'(MEM_STALL), 32'd0);
        check("b2b_lw_result", MEM_RESULT, 32'hCAFEF00D);
        check("b2b_lw_rd", 32'(MEM_RD), 32'd10);
        check("b2b_lw_we", 32'(MEM_WRITE_ENABLE), 32'd1);
        step;
        nop_ex;
        @(negedge CLK);
        check("b2b_add_result", MEM_RESULT, 32'h55);
        check("b2b_add_rd", 32'(MEM_RD), 32'd7);
        check("b2b_add_we", 32'(MEM_WRITE_ENABLE), 32'd1);

`ifdef MEM_MISALIGN_TRAP_EN
        step;
        drive(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd3, 1'b1, 1'b1);
        @(negedge CLK);
        check("mis_stall", 32'(MEM_STALL), 32'd0);
        step;
        nop_ex;
        @(negedge CLK);
        check("mis_flag", 32'(MEM_MISALIGN), 32'd1);
        check("mis_read", 32'(DMEM_READ), 32'd0);
        check("mis_we", 32'(MEM_WRITE_ENABLE), 32'd0);
        check("mis_rd", 32'(MEM_RD), 32'd3);
        check("mis_result", MEM_RESULT, 32'h102);
        step;
        @(negedge CLK);
        check("mis_flag_clear", 32'(MEM_MISALIGN), 32'd0);
`else
        run_mem(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd3, 1'b1, 1'b1, 32'h11223344, 0,
                stalls, a0, w0, be0, rd0, wr0);
        check("mis_addr", a0, 32'h100);
        check("mis_read", 32'(rd0), 32'd1);
        check("mis_result", MEM_RESULT, 32'h11223344);
        check("mis_flag", 32'(MEM_MISALIGN), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
